// File: rtl/if_id_ctrl_pkg.sv
// Shared fetch-side constants and the fetch FSM state type.
package if_id_ctrl_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam int          MAX_STALL = 3;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_ctrl_sat_counter.sv
// Width-parameterised incrementer that sticks at MAX instead of wrapping.
module if_id_ctrl_sat_counter #(
  parameter int           W   = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment; hold once MAX is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && cnt_q != MAX) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_ctrl.sv
// PC and IF/ID register owner: applies redirect > stall > advance each edge,
// requests ID/EX bubbles, and tracks stall/flush counts plus a stall watchdog.
module if_id_ctrl
  import if_id_ctrl_pkg::*;
#(
  parameter int              XLEN      = if_id_ctrl_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = if_id_ctrl_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = if_id_ctrl_pkg::NOP_INSTR,
  parameter int              MAX_STALL = if_id_ctrl_pkg::MAX_STALL
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  input  logic [31:0]     imem_instr_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] if_id_pc_out,
  output logic [31:0]     if_id_instr_out,
  output logic            if_id_valid_out,
  output logic            id_ex_bubble_out,
  output logic [31:0]     stall_cnt_out,
  output logic [31:0]     flush_cnt_out,
  output logic            stall_err_out
);

  // Run counter only needs to reach MAX_STALL+1 to flag an over-long stall.
  localparam int          RW      = $clog2(MAX_STALL + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_STALL + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            err_q, err_d;
  logic [RW-1:0]   run_cnt;

  logic take_redir, take_stall, take_adv;

  // A redirect squashes any simultaneous stall: the stalled instr is wrong-path.
  assign take_redir = redirect_in;
  assign take_stall = stall_in & ~redirect_in;
  assign take_adv   = ~stall_in & ~redirect_in;

  // Next-state and datapath selection; BOOT follows the same rules as RUN.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    err_d        = err_q;
    unique case (state_q)
      BOOT, RUN, STALL: begin
        if (take_redir) begin
          pc_d         = redirect_pc_in;
          ifid_pc_d    = pc_q;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          state_d      = RUN;
        end else if (take_stall) begin
          // Stall is always honoured; the watchdog only reports.
          if (int'(run_cnt) >= MAX_STALL) err_d = 1'b1;
          state_d = STALL;
        end else begin
          pc_d         = pc_q + XLEN'(4);
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_instr_in;
          ifid_valid_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State, PC and IF/ID registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      err_q        <= err_d;
    end
  end

  if_id_ctrl_sat_counter #(.W(32)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(take_stall), .cnt_o(stall_cnt_out)
  );

  if_id_ctrl_sat_counter #(.W(32)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(take_redir), .cnt_o(flush_cnt_out)
  );

  // Consecutive-stall run; any non-stall edge ends the run.
  if_id_ctrl_sat_counter #(.W(RW), .MAX(RUN_MAX)) u_run_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(~take_stall), .inc_i(take_stall), .cnt_o(run_cnt)
  );

  assign pc_out           = pc_q;
  assign if_id_pc_out     = ifid_pc_q;
  assign if_id_instr_out  = ifid_instr_q;
  assign if_id_valid_out  = ifid_valid_q;
  assign stall_err_out    = err_q;
  assign id_ex_bubble_out = stall_in | redirect_in;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Scoreboard bench for if_id_ctrl: a reference model predicts every edge,
// predictions are queued when stimulus is driven and popped after the edge.
module tb_if_id_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] scnt;
    logic [31:0] fcnt;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0, redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic [31:0] imem_instr_in;
  logic [31:0] pc_out, if_id_pc_out, if_id_instr_out, stall_cnt_out, flush_cnt_out;
  logic        if_id_valid_out, id_ex_bubble_out, stall_err_out;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  exp_t e;

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_instr, m_scnt, m_fcnt;
  logic        m_valid, m_err;
  int          m_run;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h0000_0093 ^ (a << 8);
  endfunction

  assign imem_instr_in = imem(pc_out);

  if_id_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in), .imem_instr_in(imem_instr_in), .pc_out(pc_out),
    .if_id_pc_out(if_id_pc_out), .if_id_instr_out(if_id_instr_out),
    .if_id_valid_out(if_id_valid_out), .id_ex_bubble_out(id_ex_bubble_out),
    .stall_cnt_out(stall_cnt_out), .flush_cnt_out(flush_cnt_out), .stall_err_out(stall_err_out)
  );

  function automatic exp_t obs();
    return {pc_out, if_id_pc_out, if_id_instr_out, if_id_valid_out,
            stall_cnt_out, flush_cnt_out, stall_err_out};
  endfunction

  // Drive one edge of stimulus, predict its effect, queue the prediction.
  task automatic cycle(input logic s, input logic r, input logic [31:0] rpc, input logic rst);
    @(negedge clk);
    stall_in = s; redirect_in = r; redirect_pc_in = rpc; rst_n = ~rst;
    if (rst) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
      m_scnt = 32'h0; m_fcnt = 32'h0; m_run = 0; m_err = 1'b0;
    end else if (r) begin
      m_ifpc = m_pc; m_instr = 32'h13; m_valid = 1'b0; m_pc = rpc;
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
      m_run = 0;
    end else if (s) begin
      if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
      m_run = (m_run + 1 > 4) ? 4 : m_run + 1;
      if (m_run > 3) m_err = 1'b1;
    end else begin
      m_ifpc = m_pc; m_instr = imem(m_pc); m_valid = 1'b1; m_pc = m_pc + 32'd4;
      m_run = 0;
    end
    sb.push_back({m_pc, m_ifpc, m_instr, m_valid, m_scnt, m_fcnt, m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 1);
    void'(sb.pop_front());
    cycle(1, 1, 32'h44, 1);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_state got %h want %h", obs(), e); end
    checks++;
    if ({pc_out, if_id_valid_out, if_id_instr_out, stall_cnt_out, flush_cnt_out} !== {32'h0, 1'b0, 32'h13, 64'h0}) begin
      errors++; $display("FAIL reset_consts got pc=%h v=%b i=%h", pc_out, if_id_valid_out, if_id_instr_out);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL advance%0d got %h want %h", i, obs(), e); end
    end
    checks++;
    if ({pc_out, if_id_pc_out, if_id_valid_out} !== {32'hC, 32'h8, 1'b1}) begin
      errors++; $display("FAIL advance3_consts got pc=%h ifpc=%h v=%b", pc_out, if_id_pc_out, if_id_valid_out);
    end
  endtask

  task automatic test_stall();
    cycle(0, 0, 0, 0);
    void'(sb.pop_front());
    cycle(1, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL stall got %h want %h", obs(), e); end
    checks++;
    if ({id_ex_bubble_out, pc_out, stall_cnt_out} !== {1'b1, 32'h10, 32'h1}) begin
      errors++; $display("FAIL stall_consts got b=%b pc=%h sc=%h", id_ex_bubble_out, pc_out, stall_cnt_out);
    end
    cycle(0, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e || id_ex_bubble_out !== 1'b0) begin
      errors++; $display("FAIL stall_resume got %h b=%b want %h b=0", obs(), id_ex_bubble_out, e);
    end
  endtask

  task automatic test_redirect();
    cycle(0, 1, 32'h200, 0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL redirect got %h want %h", obs(), e); end
    checks++;
    if ({pc_out, if_id_valid_out, if_id_instr_out, flush_cnt_out} !== {32'h200, 1'b0, 32'h13, 32'h1}) begin
      errors++; $display("FAIL redirect_consts got pc=%h v=%b fc=%h", pc_out, if_id_valid_out, flush_cnt_out);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 0);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL redirect_fetch%0d got %h want %h", i, obs(), e); end
    end
  endtask

  task automatic test_stall_redirect();
    cycle(1, 1, 32'h300, 0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e || id_ex_bubble_out !== 1'b1) begin
      errors++; $display("FAIL stall_redirect got %h b=%b want %h b=1", obs(), id_ex_bubble_out, e);
    end
    cycle(0, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL stall_redirect_next got %h want %h", obs(), e); end
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      if (i == 2) begin
        // state after the third stall edge cannot be re-read; compare the last
      end
    end
    checks++;
    if (obs() !== e || stall_err_out !== 1'b0) begin
      errors++; $display("FAIL watchdog3 got %h err=%b want %h err=0", obs(), stall_err_out, e);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL watchdog4_%0d got %h want %h", i, obs(), e); end
    end
    checks++;
    if (stall_err_out !== 1'b1) begin errors++; $display("FAIL watchdog_err got %b want 1", stall_err_out); end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 0);
      e = sb.pop_front();
      checks++;
      if (obs() !== e || stall_err_out !== 1'b1) begin
        errors++; $display("FAIL watchdog_sticky%0d got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_pc_wrap();
    cycle(0, 1, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    void'(sb.pop_front());
    void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if (obs() !== e || pc_out !== 32'h4) begin
      errors++; $display("FAIL pc_wrap got %h pc=%h want %h pc=4", obs(), pc_out, e);
    end
  endtask

  task automatic test_reset_mid_stall();
    cycle(1, 0, 0, 0);
    void'(sb.pop_front());
    cycle(1, 0, 0, 1);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_mid_stall got %h want %h", obs(), e); end
    checks++;
    if ({stall_err_out, if_id_valid_out, pc_out, stall_cnt_out} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL reset_mid_stall_consts got err=%b v=%b pc=%h sc=%h",
                         stall_err_out, if_id_valid_out, pc_out, stall_cnt_out);
    end
    cycle(0, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_first_fetch got %h want %h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_watchdog();
    test_pc_wrap();
    test_reset_mid_stall();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_ctrl.md
# if_id_ctrl

Fetch-side consumer of the hazard unit's stall request. It owns the PC register and the IF/ID pipeline register. Each cycle it applies stall (hold), redirect (flush), or normal advance, and raises the ID/EX bubble request. It also keeps stall and flush performance counters and a watchdog for over-long stalls. It sits between instruction memory, the hazard/stall unit and the ID stage of the 5-stage pipelined CPU.

## Interface
Parameters:
- XLEN, 32, PC and data width
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INSTR, 32'h0000_0013, instruction injected on flush (addi x0,x0,0)
- MAX_STALL, 3, longest legal run of consecutive stall cycles

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk, input, 1, rising-edge clock
  - rst_n, input, 1, synchronous active-low reset
- Hazard and redirect inputs:
  - stall_in, input, 1, stall request from the hazard unit (combinational, same cycle)
  - redirect_in, input, 1, taken branch or jump resolved in EX
  - redirect_pc_in, input, XLEN, redirect target
- Fetch:
  - imem_instr_in, input, 32, instruction at pc_out (combinational imem)
  - pc_out, output, XLEN, current fetch PC
- IF/ID register:
  - if_id_pc_out, output, XLEN, IF/ID PC
  - if_id_instr_out, output, 32, IF/ID instruction
  - if_id_valid_out, output, 1, IF/ID holds a real instruction
- Control and status:
  - id_ex_bubble_out, output, 1, zero ID/EX control this edge
  - stall_cnt_out, output, 32, total stall cycles
  - flush_cnt_out, output, 32, total redirects
  - stall_err_out, output, 1, sticky watchdog error

## Operation
- FSM states:
  - BOOT: first cycle after reset; IF/ID invalid.
  - RUN: normal advance.
  - STALL: holding.
- Per rising edge, when rst_n=1, the priority is redirect > stall > advance.
- Redirect (redirect_in=1, any state):
  - pc <= redirect_pc_in
  - IF/ID <= {pc_out, NOP_INSTR}, valid 0
  - flush_cnt +1
  - next state RUN
  - Any simultaneous stall is discarded; the stalled instruction is on the wrong path.
- Stall (stall_in=1, redirect_in=0):
  - PC and IF/ID hold.
  - stall_cnt +1; run counter +1.
  - next state STALL
- Advance (both 0):
  - pc <= pc+4
  - IF/ID <= {pc_out, imem_instr_in}, valid 1
  - run counter cleared
  - next state RUN
- BOOT behaves as RUN for the transition rules. It exists only so valid stays 0 until the first real fetch latches.
- id_ex_bubble_out = stall_in | redirect_in, combinational, and is also driven during BOOT.
- Watchdog:
  - The run counter counts consecutive stall cycles and saturates at MAX_STALL+1.
  - When it exceeds MAX_STALL, stall_err_out sets and stays set until reset.
  - Stall is still honoured; the error is reported only.
- Arithmetic:
  - pc+4 wraps modulo 2^XLEN.
  - stall_cnt and flush_cnt saturate at 32'hFFFF_FFFF and never wrap.
  - redirect_pc_in is used verbatim; there is no alignment check.

## Timing
- Reset values (rst_n=0 at an edge):
  - pc_out=RESET_PC
  - if_id_pc_out=0, if_id_instr_out=NOP_INSTR, if_id_valid_out=0
  - counters=0, stall_err_out=0
  - state BOOT
- Reset mid-stall or mid-redirect wins unconditionally; all state is discarded.
- Latency:
  - An instruction fetched at pc_out appears in IF/ID one edge later.
  - A redirect target appears on pc_out one edge after redirect_in.
  - The first target instruction reaches IF/ID two edges after redirect_in.
- The stall response is same-edge: the edge with stall_in=1 does not change PC or IF/ID.
- All outputs except id_ex_bubble_out are registered.

## Structure
- Shared CPU package: XLEN, NOP_INSTR, RESET_PC constants and the fetch-state enum {BOOT, RUN, STALL}.
- One sub-module is natural: sat_counter, a width-parameterised saturating incrementer. It is instantiated three times: stall count, flush count, watchdog run counter.

## Test plan
- Reset: hold rst_n=0 for 2 edges, then release.
  - Expect pc_out=0, valid=0, instr=0x13, counters 0.
  - After 3 advance edges: pc_out=0xC, if_id_pc_out=0x8, valid=1.
- Single load-use stall: at pc_out=0x10, pulse stall_in for 1 cycle.
  - Expect pc_out to stay at 0x10, IF/ID unchanged, bubble=1, stall_cnt=1.
  - Advance resumes on the next edge.
- Redirect: redirect_in=1, redirect_pc_in=0x200.
  - Expect pc_out=0x200 next edge, if_id_valid_out=0, instr=0x13, flush_cnt=1.
- Simultaneous stall and redirect.
  - Expect redirect behaviour only; stall_cnt unchanged.
- Watchdog with MAX_STALL=3:
  - 3 consecutive stalls: stall_err_out stays 0.
  - 4 consecutive stalls: stall_err_out=1, and it remains 1 after the stalls end.
- Reset mid-stall: assert rst_n=0 during a 2-cycle stall.
  - Expect all reset values, including stall_err_out=0 and state BOOT.
